// File: rtl/pcie_us_axil_rq.sv
// AXI-lite to UltraScale PCIe RQ bridge: one MWr/MRd TLP per AXI-lite write/read.
// Request handshake at N gives tvalid at N+1; outputs hold while tready is low; B follows the last write beat by one cycle.
module pcie_us_axil_rq #(
    parameter int AXIS_PCIE_DATA_WIDTH    = 256,
    parameter int AXIS_PCIE_KEEP_WIDTH    = AXIS_PCIE_DATA_WIDTH/32,
    parameter int AXIS_PCIE_RQ_USER_WIDTH = 62,
    parameter int AXIL_ADDR_WIDTH         = 32,
    parameter int MAX_RD_OUTSTANDING      = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    output logic [AXIS_PCIE_DATA_WIDTH-1:0]    m_axis_rq_tdata,
    output logic [AXIS_PCIE_KEEP_WIDTH-1:0]    m_axis_rq_tkeep,
    output logic                               m_axis_rq_tvalid,
    input  logic                               m_axis_rq_tready,
    output logic                               m_axis_rq_tlast,
    output logic [AXIS_PCIE_RQ_USER_WIDTH-1:0] m_axis_rq_tuser,
    input  logic [AXIL_ADDR_WIDTH-1:0]         s_axil_awaddr,
    input  logic                               s_axil_awvalid,
    output logic                               s_axil_awready,
    input  logic [63:0]                        s_axil_wdata,
    input  logic [7:0]                         s_axil_wstrb,
    input  logic                               s_axil_wvalid,
    output logic                               s_axil_wready,
    output logic [1:0]                         s_axil_bresp,
    output logic                               s_axil_bvalid,
    input  logic                               s_axil_bready,
    input  logic [AXIL_ADDR_WIDTH-1:0]         s_axil_araddr,
    input  logic                               s_axil_arvalid,
    output logic                               s_axil_arready,
    input  logic [15:0]                        requester_id,
    input  logic                               rd_cpl_done,
    output logic [7:0]                         rd_outstanding
);

    localparam bit WIDE = (AXIS_PCIE_DATA_WIDTH >= 256);

    typedef enum logic [1:0] {IDLE, SEND, SEND_DATA, WAIT_B} state_t;

    state_t                               state_q;
    logic                                 tvalid_q, tlast_q;
    logic [AXIS_PCIE_KEEP_WIDTH-1:0]      tkeep_q;
    logic [AXIS_PCIE_DATA_WIDTH-1:0]      tdata_q;
    logic [AXIS_PCIE_RQ_USER_WIDTH-1:0]   tuser_q;
    logic                                 awready_q, wready_q, arready_q, bvalid_q;
    logic [7:0]                           tag_q, rd_out_q, rd_out_d;
    logic                                 served_rd_q, two_dw_q;
    logic [63:0]                          payload_q;

    logic                                 beat_acc, last_acc, rd_hs, wr_hs;
    logic                                 rd_elig, wr_elig, pick_rd, pick_wr;
    logic [63:0]                          addr_d, payload_d;
    logic [3:0]                           first_be_d, last_be_d;
    logic                                 two_dw_d;
    logic [127:0]                         desc_d;
    logic [255:0]                         beat_d;
    logic [7:0]                           keep_d, keep2_d;
    logic [AXIS_PCIE_RQ_USER_WIDTH-1:0]   user_d;
    logic [AXIS_PCIE_DATA_WIDTH-1:0]      data2_d;

    assign beat_acc = tvalid_q && m_axis_rq_tready;
    assign last_acc = beat_acc && tlast_q;
    assign rd_hs    = (state_q == IDLE) && arready_q && s_axil_arvalid;
    assign wr_hs    = (state_q == IDLE) && awready_q && wready_q && s_axil_awvalid && s_axil_wvalid;

    // Arbitration looks at next-cycle credit so a read can be granted in the cycle its predecessor leaves.
    always_comb begin
        rd_out_d = rd_out_q;
        if (last_acc && served_rd_q && !rd_cpl_done)
            rd_out_d = rd_out_q + 8'd1;
        else if (rd_cpl_done && !(last_acc && served_rd_q) && rd_out_q != 8'd0)
            rd_out_d = rd_out_q - 8'd1;
        rd_elig = s_axil_arvalid && (rd_out_d < 8'(MAX_RD_OUTSTANDING));
        wr_elig = s_axil_awvalid && s_axil_wvalid;
        pick_rd = rd_elig && (!wr_elig || !served_rd_q);
        pick_wr = wr_elig && !pick_rd;
    end

    always_comb begin
        addr_d     = '0;
        payload_d  = '0;
        first_be_d = 4'h0;
        last_be_d  = 4'h0;
        two_dw_d   = 1'b0;
        if (arready_q) begin
            addr_d      = 64'(s_axil_araddr);
            addr_d[2:0] = 3'b000;
            first_be_d  = 4'hF;
            last_be_d   = 4'hF;
            two_dw_d    = 1'b1;
        end else begin
            addr_d = 64'(s_axil_awaddr);
            if (s_axil_wstrb[7:4] != 4'h0 && s_axil_wstrb[3:0] != 4'h0) begin
                first_be_d = s_axil_wstrb[3:0];
                last_be_d  = s_axil_wstrb[7:4];
                two_dw_d   = 1'b1;
                payload_d  = s_axil_wdata;
            end else if (s_axil_wstrb[7:4] == 4'h0) begin
                first_be_d = s_axil_wstrb[3:0];
                payload_d  = {32'h0, s_axil_wdata[31:0]};
            end else begin
                addr_d     = addr_d + 64'd4;
                first_be_d = s_axil_wstrb[7:4];
                payload_d  = {32'h0, s_axil_wdata[63:32]};
            end
        end
        desc_d  = {24'h0, tag_q, requester_id, 1'b0, arready_q ? 4'b0000 : 4'b0001,
                   two_dw_d ? 11'd2 : 11'd1, addr_d[63:2], 2'b00};
        beat_d  = {64'h0, payload_d, desc_d};
        keep_d  = arready_q ? 8'h0F : (two_dw_d ? 8'h3F : 8'h1F);
        keep2_d = two_dw_q ? 8'h03 : 8'h01;
        user_d  = '0;
        user_d[7:0] = {last_be_d, first_be_d};
        data2_d = '0;
        data2_d[63:0] = payload_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            tkeep_q     <= '0;
            tdata_q     <= '0;
            tuser_q     <= '0;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            arready_q   <= 1'b0;
            bvalid_q    <= 1'b0;
            tag_q       <= 8'd0;
            rd_out_q    <= 8'd0;
            served_rd_q <= 1'b0;
            two_dw_q    <= 1'b0;
            payload_q   <= '0;
        end else begin
            rd_out_q  <= rd_out_d;
            arready_q <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rd_hs || wr_hs) begin
                        tvalid_q    <= 1'b1;
                        tdata_q     <= beat_d[AXIS_PCIE_DATA_WIDTH-1:0];
                        tkeep_q     <= keep_d[AXIS_PCIE_KEEP_WIDTH-1:0];
                        tuser_q     <= user_d;
                        tlast_q     <= rd_hs || WIDE;
                        served_rd_q <= rd_hs;
                        two_dw_q    <= two_dw_d;
                        payload_q   <= payload_d;
                        state_q     <= SEND;
                    end else if (!arready_q && !awready_q) begin
                        arready_q <= pick_rd;
                        awready_q <= pick_wr;
                        wready_q  <= pick_wr;
                    end
                end
                SEND: begin
                    if (beat_acc) begin
                        if (tlast_q) begin
                            tvalid_q <= 1'b0;
                            tag_q    <= tag_q + 8'd1;
                            if (served_rd_q) begin
                                state_q   <= IDLE;
                                arready_q <= pick_rd;
                                awready_q <= pick_wr;
                                wready_q  <= pick_wr;
                            end else begin
                                bvalid_q <= 1'b1;
                                state_q  <= WAIT_B;
                            end
                        end else begin
                            tdata_q <= data2_d;
                            tkeep_q <= keep2_d[AXIS_PCIE_KEEP_WIDTH-1:0];
                            tlast_q <= 1'b1;
                            state_q <= SEND_DATA;
                        end
                    end
                end
                SEND_DATA: begin
                    if (beat_acc) begin
                        tvalid_q <= 1'b0;
                        tag_q    <= tag_q + 8'd1;
                        bvalid_q <= 1'b1;
                        state_q  <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (s_axil_bready) begin
                        bvalid_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign m_axis_rq_tdata  = tdata_q;
    assign m_axis_rq_tkeep  = tkeep_q;
    assign m_axis_rq_tvalid = tvalid_q;
    assign m_axis_rq_tlast  = tlast_q;
    assign m_axis_rq_tuser  = tuser_q;
    assign s_axil_awready   = awready_q;
    assign s_axil_wready    = wready_q;
    assign s_axil_arready   = arready_q;
    assign s_axil_bvalid    = bvalid_q;
    assign s_axil_bresp     = 2'b00;
    assign rd_outstanding   = rd_out_q;

endmodule

// File: tb/tb_pcie_us_axil_rq.sv
// Directed bench for pcie_us_axil_rq: 256-bit instance with two read credits, plus a 128-bit instance.
module tb_pcie_us_axil_rq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [15:0] rid = 16'hABCD;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    logic [255:0] a_tdata;  logic [7:0] a_tkeep;  logic a_tvalid, a_tready, a_tlast;
    logic [61:0]  a_tuser;  logic [31:0] a_awaddr, a_araddr;
    logic a_awvalid, a_awready, a_wvalid, a_wready, a_bvalid, a_bready, a_arvalid, a_arready, a_cpl;
    logic [63:0] a_wdata;   logic [7:0] a_wstrb, a_rdout;  logic [1:0] a_bresp;

    logic [127:0] b_tdata;  logic [3:0] b_tkeep;  logic b_tvalid, b_tready, b_tlast;
    logic [61:0]  b_tuser;  logic [31:0] b_awaddr, b_araddr;
    logic b_awvalid, b_awready, b_wvalid, b_wready, b_bvalid, b_bready, b_arvalid, b_arready, b_cpl;
    logic [63:0] b_wdata;   logic [7:0] b_wstrb, b_rdout;  logic [1:0] b_bresp;

    pcie_us_axil_rq #(.MAX_RD_OUTSTANDING(2)) u_dut256 (
        .clk(clk), .rst(rst),
        .m_axis_rq_tdata(a_tdata), .m_axis_rq_tkeep(a_tkeep), .m_axis_rq_tvalid(a_tvalid),
        .m_axis_rq_tready(a_tready), .m_axis_rq_tlast(a_tlast), .m_axis_rq_tuser(a_tuser),
        .s_axil_awaddr(a_awaddr), .s_axil_awvalid(a_awvalid), .s_axil_awready(a_awready),
        .s_axil_wdata(a_wdata), .s_axil_wstrb(a_wstrb), .s_axil_wvalid(a_wvalid), .s_axil_wready(a_wready),
        .s_axil_bresp(a_bresp), .s_axil_bvalid(a_bvalid), .s_axil_bready(a_bready),
        .s_axil_araddr(a_araddr), .s_axil_arvalid(a_arvalid), .s_axil_arready(a_arready),
        .requester_id(rid), .rd_cpl_done(a_cpl), .rd_outstanding(a_rdout)
    );

    pcie_us_axil_rq #(.AXIS_PCIE_DATA_WIDTH(128)) u_dut128 (
        .clk(clk), .rst(rst),
        .m_axis_rq_tdata(b_tdata), .m_axis_rq_tkeep(b_tkeep), .m_axis_rq_tvalid(b_tvalid),
        .m_axis_rq_tready(b_tready), .m_axis_rq_tlast(b_tlast), .m_axis_rq_tuser(b_tuser),
        .s_axil_awaddr(b_awaddr), .s_axil_awvalid(b_awvalid), .s_axil_awready(b_awready),
        .s_axil_wdata(b_wdata), .s_axil_wstrb(b_wstrb), .s_axil_wvalid(b_wvalid), .s_axil_wready(b_wready),
        .s_axil_bresp(b_bresp), .s_axil_bvalid(b_bvalid), .s_axil_bready(b_bready),
        .s_axil_araddr(b_araddr), .s_axil_arvalid(b_arvalid), .s_axil_arready(b_arready),
        .requester_id(rid), .rd_cpl_done(b_cpl), .rd_outstanding(b_rdout)
    );

    task automatic clear_inputs;
        a_awaddr = '0; a_araddr = '0; a_wdata = '0; a_wstrb = '0;
        a_awvalid = 0; a_wvalid = 0; a_arvalid = 0; a_bready = 0; a_cpl = 0; a_tready = 1;
        b_awaddr = '0; b_araddr = '0; b_wdata = '0; b_wstrb = '0;
        b_awvalid = 0; b_wvalid = 0; b_arvalid = 0; b_bready = 0; b_cpl = 0; b_tready = 1;
    endtask

    task automatic apply_reset;
        clear_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    task automatic test_reset;
        bit ok;
        logic [255:0] held;
        clear_inputs();
        @(posedge clk); #1;
        checks++; if ({a_tvalid, a_tlast, a_awready, a_wready, a_arready, a_bvalid} !== 6'b0) begin
            failures++; $display("FAIL reset_ctl256 got=%b exp=000000", {a_tvalid, a_tlast, a_awready, a_wready, a_arready, a_bvalid}); end
        checks++; if (a_tdata !== 256'h0 || a_tkeep !== 8'h0 || a_tuser !== 62'h0) begin
            failures++; $display("FAIL reset_data256 tdata=%0h tkeep=%0h tuser=%0h exp=0", a_tdata, a_tkeep, a_tuser); end
        checks++; if (a_rdout !== 8'd0) begin failures++; $display("FAIL reset_rdout got=%0d exp=0", a_rdout); end
        checks++; if ({b_tvalid, b_tlast, b_awready, b_wready, b_arready, b_bvalid} !== 6'b0 || b_tdata !== 128'h0
                      || b_tkeep !== 4'h0 || b_tuser !== 62'h0 || b_rdout !== 8'd0) begin
            failures++; $display("FAIL reset_128 tvalid=%b tdata=%0h rdout=%0d exp=0", b_tvalid, b_tdata, b_rdout); end

        rst = 0; a_tready = 0; a_araddr = 32'h40; a_arvalid = 1;
        ok = 0;
        for (int i = 0; i < 20; i++) begin @(posedge clk); #1; if (a_arready) begin ok = 1; break; end end
        checks++; if (!ok) begin failures++; $display("FAIL reset_arready_wait got=timeout exp=arready"); end
        @(posedge clk); #1; a_arvalid = 0;
        checks++; if (a_tvalid !== 1'b1) begin failures++; $display("FAIL read_latency tvalid=%b exp=1", a_tvalid); end
        held = a_tdata;
        repeat (2) @(posedge clk); #1;
        checks++; if (a_tvalid !== 1'b1 || a_tdata !== held) begin
            failures++; $display("FAIL stall_hold tvalid=%b tdata=%0h exp=%0h", a_tvalid, a_tdata, held); end
        #3 rst = 1; #1;
        checks++; if (a_tvalid !== 1'b0 || a_tdata !== 256'h0 || a_rdout !== 8'd0 || a_arready !== 1'b0) begin
            failures++; $display("FAIL async_reset tvalid=%b tdata=%0h rdout=%0d exp=0", a_tvalid, a_tdata, a_rdout); end
        @(posedge clk); #1; rst = 0; a_tready = 1;
    endtask

    task automatic test_read;
        bit ok;
        a_araddr = 32'h1004; a_arvalid = 1; ok = 0;
        for (int i = 0; i < 20; i++) begin @(posedge clk); #1; if (a_arready) begin ok = 1; break; end end
        checks++; if (!ok) begin failures++; $display("FAIL read_arready_wait got=timeout exp=arready"); end
        @(posedge clk); #1; a_arvalid = 0;
        checks++; if (a_tdata !== {128'h0, 64'h0000_0000_ABCD_0002, 64'h0000_0000_0000_1000}) begin
            failures++; $display("FAIL read_desc got=%0h exp=0000000000abcd00020000000000001000", a_tdata); end
        checks++; if (a_tuser !== 62'hFF || a_tkeep !== 8'h0F || a_tlast !== 1'b1 || a_tvalid !== 1'b1) begin
            failures++; $display("FAIL read_side tuser=%0h tkeep=%0h tlast=%b exp=ff/0f/1", a_tuser, a_tkeep, a_tlast); end
        @(posedge clk); #1;
        checks++; if (a_rdout !== 8'd1 || a_tvalid !== 1'b0) begin
            failures++; $display("FAIL read_outstanding got=%0d tvalid=%b exp=1/0", a_rdout, a_tvalid); end
    endtask

    task automatic test_write_patterns;
        logic [31:0] addr_t [6] = '{32'h2000, 32'h2100, 32'h2200, 32'h2300, 32'h2400, 32'h2507};
        logic [63:0] wd_t   [6] = '{64'h1122334455667788, 64'h1122334455667788, 64'hAABBCCDDEEFF0011,
                                    64'hAABBCCDDEEFF0011, 64'hAABBCCDDEEFF0011, 64'hAABBCCDDEEFF0011};
        logic [7:0]  ws_t   [6] = '{8'hF0, 8'h0F, 8'hFF, 8'h3C, 8'h00, 8'h01};
        logic [63:0] lo_t   [6] = '{64'h2004, 64'h2100, 64'h2200, 64'h2300, 64'h2400, 64'h2504};
        logic [10:0] cnt_t  [6] = '{11'd1, 11'd1, 11'd2, 11'd2, 11'd1, 11'd1};
        logic [3:0]  fbe_t  [6] = '{4'hF, 4'hF, 4'hF, 4'hC, 4'h0, 4'h1};
        logic [3:0]  lbe_t  [6] = '{4'h0, 4'h0, 4'hF, 4'h3, 4'h0, 4'h0};
        logic [63:0] pay_t  [6] = '{64'h11223344, 64'h55667788, 64'hAABBCCDDEEFF0011,
                                    64'hAABBCCDDEEFF0011, 64'hEEFF0011, 64'hEEFF0011};
        logic [7:0]  keep_t [6] = '{8'h1F, 8'h1F, 8'h3F, 8'h3F, 8'h1F, 8'h1F};
        logic [7:0]  exp_tag = 8'd1;
        logic [255:0] exp;
        bit ok;
        for (int i = 0; i < 6; i++) begin
            a_awaddr = addr_t[i]; a_wdata = wd_t[i]; a_wstrb = ws_t[i];
            a_awvalid = 1; a_wvalid = 1; a_bready = 0; ok = 0;
            for (int k = 0; k < 20; k++) begin @(posedge clk); #1; if (a_awready) begin ok = 1; break; end end
            checks++; if (!ok || a_wready !== 1'b1) begin
                failures++; $display("FAIL wr%0d_ready awready=%b wready=%b exp=1/1", i, a_awready, a_wready); end
            @(posedge clk); #1; a_awvalid = 0; a_wvalid = 0;
            exp = {64'h0, pay_t[i], 24'h0, exp_tag, 16'hABCD, 1'b0, 4'b0001, cnt_t[i], lo_t[i]};
            checks++; if (a_tdata !== exp) begin
                failures++; $display("FAIL wr%0d_tdata got=%0h exp=%0h", i, a_tdata, exp); end
            checks++; if (a_tuser !== {54'h0, lbe_t[i], fbe_t[i]} || a_tkeep !== keep_t[i] || a_tlast !== 1'b1) begin
                failures++; $display("FAIL wr%0d_side tuser=%0h tkeep=%0h tlast=%b exp=%0h/%0h/1",
                                     i, a_tuser, a_tkeep, a_tlast, {lbe_t[i], fbe_t[i]}, keep_t[i]); end
            @(posedge clk); #1;
            checks++; if (a_bvalid !== 1'b1 || a_bresp !== 2'b00 || a_tvalid !== 1'b0) begin
                failures++; $display("FAIL wr%0d_b bvalid=%b bresp=%0d tvalid=%b exp=1/0/0", i, a_bvalid, a_bresp, a_tvalid); end
            @(posedge clk); #1;
            checks++; if (a_bvalid !== 1'b1) begin failures++; $display("FAIL wr%0d_bhold bvalid=%b exp=1", i, a_bvalid); end
            a_bready = 1;
            @(posedge clk); #1; a_bready = 0;
            checks++; if (a_bvalid !== 1'b0) begin failures++; $display("FAIL wr%0d_bclear bvalid=%b exp=0", i, a_bvalid); end
            exp_tag = exp_tag + 8'd1;
        end
    endtask

    task automatic test_outstanding;
        int n = 0;
        int cyc [2];
        logic [7:0] tg [2];
        bit saw_ar = 0;
        bit ok = 0;
        apply_reset();
        a_araddr = 32'h100; a_arvalid = 1;
        for (int c = 0; c < 14; c++) begin
            @(posedge clk); #1;
            if (a_tvalid) begin
                if (n < 2) begin cyc[n] = c; tg[n] = a_tdata[103:96]; end
                n++;
            end
            if (n >= 2 && a_arready) saw_ar = 1;
        end
        checks++; if (n != 2) begin failures++; $display("FAIL credit_reads got=%0d exp=2", n); end
        checks++; if (cyc[1] - cyc[0] != 2) begin failures++; $display("FAIL read_spacing got=%0d exp=2", cyc[1] - cyc[0]); end
        checks++; if (tg[0] !== 8'd0 || tg[1] !== 8'd1) begin
            failures++; $display("FAIL credit_tags got=%0d,%0d exp=0,1", tg[0], tg[1]); end
        checks++; if (saw_ar || a_rdout !== 8'd2) begin
            failures++; $display("FAIL credit_block arready_seen=%b rdout=%0d exp=0/2", saw_ar, a_rdout); end
        a_cpl = 1;
        @(posedge clk); #1; a_cpl = 0;
        checks++; if (a_rdout !== 8'd1) begin failures++; $display("FAIL cpl_dec got=%0d exp=1", a_rdout); end
        for (int c = 0; c < 10; c++) begin @(posedge clk); #1; if (a_tvalid) begin ok = 1; break; end end
        a_arvalid = 0;
        checks++; if (!ok || a_tdata[103:96] !== 8'd2) begin
            failures++; $display("FAIL third_read seen=%b tag=%0d exp=1/2", ok, a_tdata[103:96]); end
        @(posedge clk); #1;
        checks++; if (a_rdout !== 8'd2) begin failures++; $display("FAIL third_rdout got=%0d exp=2", a_rdout); end
    endtask

    task automatic test_alternate;
        logic [3:0] ty [4];
        int n = 0;
        apply_reset();
        a_bready = 1; a_cpl = 1;
        a_araddr = 32'h200; a_awaddr = 32'h300; a_wdata = 64'h0123456789ABCDEF; a_wstrb = 8'hFF;
        a_arvalid = 1; a_awvalid = 1; a_wvalid = 1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (a_tvalid && n < 4) begin ty[n] = a_tdata[78:75]; n++; end
        end
        a_arvalid = 0; a_awvalid = 0; a_wvalid = 0; a_cpl = 0;
        checks++; if (n != 4) begin failures++; $display("FAIL alt_count got=%0d exp=4", n); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (ty[i] !== ((i % 2 == 0) ? 4'b0000 : 4'b0001)) begin
                failures++; $display("FAIL alt_type%0d got=%0h exp=%0h", i, ty[i], (i % 2 == 0) ? 0 : 1); end
        end
        repeat (4) @(posedge clk);
    endtask

    task automatic test_w128;
        logic [127:0] bd [2];
        logic [3:0]   bk [2];
        logic         bl [2];
        logic [127:0] pd;
        logic [3:0]   pk;
        logic         pl;
        int nb = 0;
        int unstable = 0;
        bit stalled = 0;
        bit saw_b = 0;
        bit ok = 0;
        logic [61:0] u1;
        apply_reset();
        b_bready = 1; b_awaddr = 32'h3008; b_wdata = 64'hCAFEBABE_DEADBEEF; b_wstrb = 8'hFF;
        b_awvalid = 1; b_wvalid = 1;
        for (int k = 0; k < 20; k++) begin @(posedge clk); #1; if (b_awready) begin ok = 1; break; end end
        checks++; if (!ok || b_wready !== 1'b1) begin
            failures++; $display("FAIL w128_ready awready=%b wready=%b exp=1/1", b_awready, b_wready); end
        @(posedge clk); #1; b_awvalid = 0; b_wvalid = 0;
        u1 = b_tuser;
        for (int c = 0; c < 16; c++) begin
            b_tready = ~b_tready;
            if (b_tvalid) begin
                if (stalled && (b_tdata !== pd || b_tkeep !== pk || b_tlast !== pl)) unstable++;
                if (b_tready) begin
                    if (nb < 2) begin bd[nb] = b_tdata; bk[nb] = b_tkeep; bl[nb] = b_tlast; end
                    nb++; stalled = 0;
                end else begin
                    stalled = 1; pd = b_tdata; pk = b_tkeep; pl = b_tlast;
                end
            end
            if (b_bvalid && b_bresp === 2'b00) saw_b = 1;
            @(posedge clk); #1;
        end
        checks++; if (nb != 2) begin failures++; $display("FAIL w128_beats got=%0d exp=2", nb); end
        checks++; if (bd[0] !== {64'h0000_0000_ABCD_0802, 64'h0000_0000_0000_3008} || bk[0] !== 4'hF || bl[0] !== 1'b0) begin
            failures++; $display("FAIL w128_beat1 tdata=%0h tkeep=%0h tlast=%b exp=abcd08020000000000003008/f/0", bd[0], bk[0], bl[0]); end
        checks++; if (u1 !== 62'hFF) begin failures++; $display("FAIL w128_tuser got=%0h exp=ff", u1); end
        checks++; if (bd[1] !== {64'h0, 64'hCAFEBABE_DEADBEEF} || bk[1] !== 4'h3 || bl[1] !== 1'b1) begin
            failures++; $display("FAIL w128_beat2 tdata=%0h tkeep=%0h tlast=%b exp=cafebabedeadbeef/3/1", bd[1], bk[1], bl[1]); end
        checks++; if (unstable != 0) begin failures++; $display("FAIL w128_stall_stable got=%0d exp=0", unstable); end
        checks++; if (!saw_b) begin failures++; $display("FAIL w128_bvalid got=none exp=bvalid with bresp 0"); end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_patterns();
        test_outstanding();
        test_alternate();
        test_w128();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
